// File: rtl/reg_scan_pkg.sv
// Shared constants and types for the change-detecting register array scanner.
// Imported by reg_scan_pick and reg_array_scan.
package reg_scan_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/reg_scan_pick.sv
// Combinational lowest-index priority encoder over the pending flags.
// 'any' is high when at least one flag is set; 'sel' is then the lowest set index.
module reg_scan_pick
    import reg_scan_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEF_DEPTH)
) (
    input  logic [DEPTH-1:0] pending,
    output logic             any,
    output logic [IDX_W-1:0] sel
);

    always_comb begin
        any = |pending;
        sel = '0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reg_array_scan.sv
// Watches a flattened register array, remembers which entries changed and
// serializes each changed entry once as an (index, value) valid/ready record.
module reg_array_scan
    import reg_scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEPTH*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_index,
    output logic [WIDTH-1:0]       out_data,
    output logic [DEPTH-1:0]       pending,
    output logic [7:0]             drop_count
);

    logic [WIDTH-1:0] shadow_reg [DEPTH];
    logic [DEPTH-1:0] change;
    logic [DEPTH-1:0] dup;
    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] pending_next;
    logic [DEPTH-1:0] clear_mask;

    state_t           state_reg;
    state_t           state_next;
    logic [IDX_W-1:0] out_index_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [7:0]       drop_reg;
    logic [7:0]       drop_next;
    logic [15:0]      drop_sum;

    logic             pick_any;
    logic [IDX_W-1:0] pick_sel;
    logic             load;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign change[gi] = (in_data[gi*WIDTH +: WIDTH] != shadow_reg[gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (change[gi]) begin
                    shadow_reg[gi] <= in_data[gi*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

    // A change landing on an entry that is still waiting supersedes the older value.
    assign dup = change & pending_reg;

    reg_scan_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending (pending_reg),
        .any     (pick_any),
        .sel     (pick_sel)
    );

    assign load = pick_any && ((state_reg == IDLE) || out_ready);

    always_comb begin
        state_next = state_reg;
        clear_mask = '0;
        if (load) begin
            state_next = HOLD;
            clear_mask = {{(DEPTH-1){1'b0}}, 1'b1} << pick_sel;
        end else if ((state_reg == HOLD) && out_ready) begin
            state_next = IDLE;
        end
        // Set wins over clear so a value arriving during the load is reported later.
        pending_next = (pending_reg & ~clear_mask) | change;
    end

    always_comb begin
        drop_sum = 16'(drop_reg);
        for (int i = 0; i < DEPTH; i++) begin
            drop_sum = drop_sum + 16'(dup[i]);
        end
        drop_next = (drop_sum > 16'(DROP_MAX)) ? DROP_MAX : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            out_index_reg <= '0;
            out_data_reg  <= '0;
            drop_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            drop_reg    <= drop_next;
            if (load) begin
                out_index_reg <= pick_sel;
                out_data_reg  <= shadow_reg[pick_sel];
            end
        end
    end

    assign out_valid  = (state_reg == HOLD);
    assign out_index  = out_index_reg;
    assign out_data   = out_data_reg;
    assign pending    = pending_reg;
    assign drop_count = drop_reg;

endmodule

// File: tb/tb_reg_array_scan.sv
// Scoreboard bench for reg_array_scan: expected records are queued as stimulus is
// driven and compared, in order, whenever the DUT transfers a record.
module tb_reg_array_scan;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_index;
    logic [7:0]  out_data;
    logic [3:0]  pending;
    logic [7:0]  drop_count;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rx     = 0;

    reg_array_scan #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_data   (out_data),
        .pending    (pending),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_entry(input int idx, input logic [7:0] v);
        in_data[idx*8 +: 8] = v;
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] data);
        rec_t r;
        r.idx  = idx;
        r.data = data;
        exp_q.push_back(r);
    endtask

    // Inputs only change just after a rising edge, so a valid/ready pair seen here
    // is the transfer that happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rec_t r;
            n_rx++;
            check("record_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("rec_index", 32'(out_index), 32'(r.idx));
                check("rec_data", 32'(out_data), 32'(r.data));
                $display("record %0d: index=%0d data=%0h", n_rx, out_index, out_data);
            end
        end
    end

    initial begin
        // Reset with a nonzero array; entries 1..3 must be reported afterwards.
        rst       = 1'b1;
        out_ready = 1'b1;
        in_data   = {8'd3, 8'd2, 8'd1, 8'd0};
        step(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_index", 32'(out_index), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        push(2'd1, 8'd1);
        push(2'd2, 8'd2);
        push(2'd3, 8'd3);
        rst = 1'b0;
        step(1);
        check("t1_valid_e1", 32'(out_valid), 32'd0);
        check("t1_pending_e1", 32'(pending), 32'b1110);
        step(1);
        check("t1_valid_e2", 32'(out_valid), 32'd1);
        check("t1_index_e2", 32'(out_index), 32'd1);
        step(1);
        check("t1_index_e3", 32'(out_index), 32'd2);
        step(1);
        check("t1_index_e4", 32'(out_index), 32'd3);
        step(2);
        check("t1_idle", 32'(out_valid), 32'd0);
        check("t1_pending_done", 32'(pending), 32'd0);
        check("t1_drop", 32'(drop_count), 32'd0);

        // Single change from idle appears two edges later.
        set_entry(0, 8'd4);
        push(2'd0, 8'd4);
        step(1);
        check("t2_pending", 32'(pending), 32'b0001);
        check("t2_valid_e1", 32'(out_valid), 32'd0);
        step(1);
        check("t2_valid_e2", 32'(out_valid), 32'd1);
        check("t2_index", 32'(out_index), 32'd0);
        check("t2_data", 32'(out_data), 32'd4);
        step(1);
        check("t2_idle", 32'(out_valid), 32'd0);
        check("t2_pending_done", 32'(pending), 32'd0);

        // Backpressure: two changes on entry 1 coalesce into one record.
        out_ready = 1'b0;
        set_entry(3, 8'd7);
        push(2'd3, 8'd7);
        step(2);
        check("t3_hold_valid", 32'(out_valid), 32'd1);
        check("t3_hold_index", 32'(out_index), 32'd3);
        set_entry(1, 8'd5);
        step(1);
        check("t3_pending", 32'(pending), 32'b0010);
        check("t3_drop0", 32'(drop_count), 32'd0);
        set_entry(1, 8'd9);
        step(1);
        check("t3_drop1", 32'(drop_count), 32'd1);
        check("t3_stable_index", 32'(out_index), 32'd3);
        check("t3_stable_data", 32'(out_data), 32'd7);
        push(2'd1, 8'd9);
        out_ready = 1'b1;
        step(2);
        check("t3_idle", 32'(out_valid), 32'd0);
        check("t3_pending_done", 32'(pending), 32'd0);
        check("t3_drop_final", 32'(drop_count), 32'd1);

        // Entry 2 changes on the very edge it is loaded.
        set_entry(2, 8'h20);
        step(1);
        check("t4_pending_a", 32'(pending), 32'b0100);
        set_entry(2, 8'h21);
        push(2'd2, 8'h20);
        push(2'd2, 8'h21);
        step(1);
        check("t4_valid_old", 32'(out_valid), 32'd1);
        check("t4_data_old", 32'(out_data), 32'h20);
        check("t4_pending_kept", 32'(pending), 32'b0100);
        step(1);
        check("t4_data_new", 32'(out_data), 32'h21);
        check("t4_pending_done", 32'(pending), 32'd0);
        step(1);
        check("t4_idle", 32'(out_valid), 32'd0);

        // Drop counter saturation under held backpressure.
        set_entry(3, 8'h30);
        step(1);
        out_ready = 1'b0;
        step(1);
        check("t5_hold_valid", 32'(out_valid), 32'd1);
        check("t5_hold_data", 32'(out_data), 32'h30);
        for (int i = 0; i < 300; i++) begin
            set_entry(0, (i % 2 == 1) ? 8'h55 : 8'hAA);
            step(1);
        end
        check("t5_drop_sat", 32'(drop_count), 32'd255);
        check("t5_pending", 32'(pending), 32'b0001);
        check("t5_stable_data", 32'(out_data), 32'h30);

        // Reset while holding a record with work pending.
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        check("t6_index", 32'(out_index), 32'd0);
        check("t6_data", 32'(out_data), 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        step(1);
        push(2'd0, 8'h55);
        push(2'd1, 8'd9);
        push(2'd2, 8'h21);
        push(2'd3, 8'h30);
        rst = 1'b0;
        step(1);
        check("t6_rereport", 32'(pending), 32'b1111);
        step(6);
        check("t6_idle", 32'(out_valid), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("records_total", 32'(n_rx), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
